// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit types and the byte-lane mask helper
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_RSVD  = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_SIZE     = 2'b10,
    FLT_TIMEOUT  = 2'b11
  } lsu_fault_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } lsu_state_e;

  // Mask is built for the widest (8-lane) bus; callers truncate to their lane count.
  function automatic logic [7:0] lane_mask(input lsu_size_e size, input logic [2:0] offset);
    logic [7:0] ones;
    case (size)
      SZ_BYTE: ones = 8'h01;
      SZ_HALF: ones = 8'h03;
      SZ_WORD: ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << offset;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - store lane replication/byte enables and load extract/extend
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DBUS = 32,
  localparam int NB = DBUS / 8,
  localparam int OW = $clog2(NB)
) (
  input  lsu_size_e        st_size_i,
  input  logic [OW-1:0]    st_off_i,
  input  logic [DBUS-1:0]  st_wdata_i,
  output logic [DBUS-1:0]  st_data_o,
  output logic [NB-1:0]    st_be_o,
  input  lsu_size_e        ld_size_i,
  input  logic [OW-1:0]    ld_off_i,
  input  logic             ld_signed_i,
  input  logic [DBUS-1:0]  ld_rdata_i,
  output logic [DBUS-1:0]  ld_data_o
);

  logic [DBUS-1:0] shifted;
  logic            sign_bit;
  int              nbits;

  always_comb begin
    st_be_o = NB'(lane_mask(st_size_i, 3'(st_off_i)));
    case (st_size_i)
      SZ_BYTE: st_data_o = {NB{st_wdata_i[7:0]}};
      SZ_HALF: st_data_o = {(NB/2){st_wdata_i[15:0]}};
      SZ_WORD: st_data_o = {(NB/4){st_wdata_i[31:0]}};
      default: st_data_o = st_wdata_i;
    endcase
  end

  // Bits at or above the access width are filled with the sign (or zero);
  // a full-width access has nbits >= DBUS and so is passed through untouched.
  always_comb begin
    shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    nbits   = 8 << int'(ld_size_i);
    case (ld_size_i)
      SZ_BYTE: sign_bit = shifted[7];
      SZ_HALF: sign_bit = shifted[15];
      default: sign_bit = shifted[31];
    endcase
    ld_data_o = '0;
    for (int i = 0; i < DBUS; i++) begin
      ld_data_o[i] = (i < nbits) ? shifted[i] : (ld_signed_i & sign_bit);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit: FSM, request latch, timeout, writeback and faults
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DBUS    = 32,
  parameter int ABUS    = 32,
  parameter int RBUS    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ABUS-1:0]   req_addr,
  input  logic [DBUS-1:0]   req_wdata,
  input  logic [RBUS-1:0]   req_rd,
  output logic              MRE,
  output logic              MWE,
  output logic [ABUS-1:0]   addressData,
  output logic [DBUS-1:0]   storeData,
  output logic [DBUS/8-1:0] byteEn,
  input  logic [DBUS-1:0]   loadedData,
  input  logic              memReady,
  output logic              wb_valid,
  output logic [RBUS-1:0]   wb_rd,
  output logic [DBUS-1:0]   wb_data,
  output logic              busy_rd_valid,
  output logic [RBUS-1:0]   busy_rd,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int NB = DBUS / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);

  lsu_state_e      state_q, state_d;
  logic            mre_q, mre_d, mwe_q, mwe_d;
  logic [ABUS-1:0] addr_q, addr_d;
  logic [DBUS-1:0] sdata_q, sdata_d;
  logic [NB-1:0]   be_q, be_d;
  logic            load_q, load_d;
  lsu_size_e       size_q, size_d;
  logic [OW-1:0]   off_q, off_d;
  logic            sgn_q, sgn_d;
  logic [RBUS-1:0] rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RBUS-1:0] wb_rd_q, wb_rd_d;
  logic [DBUS-1:0] wb_data_q, wb_data_d;
  logic            fault_q, fault_d;
  lsu_fault_e      fcode_q, fcode_d;

  lsu_op_e         op;
  lsu_size_e       rsize;
  lsu_fault_e      chk;
  logic [DBUS-1:0] st_data, ld_data;
  logic [NB-1:0]   st_be;

  assign op    = lsu_op_e'(req_op);
  assign rsize = lsu_size_e'(req_size);

  lsu_lane_align #(.DBUS(DBUS)) u_align (
    .st_size_i   (rsize),
    .st_off_i    (req_addr[OW-1:0]),
    .st_wdata_i  (req_wdata),
    .st_data_o   (st_data),
    .st_be_o     (st_be),
    .ld_size_i   (size_q),
    .ld_off_i    (off_q),
    .ld_signed_i (sgn_q),
    .ld_rdata_i  (loadedData),
    .ld_data_o   (ld_data)
  );

  // Illegal size is tested first so it wins over misalignment.
  always_comb begin
    chk = FLT_NONE;
    if (rsize == SZ_DOUBLE && DBUS == 32) begin
      chk = FLT_SIZE;
    end else begin
      case (rsize)
        SZ_HALF:   if (req_addr[0])        chk = FLT_MISALIGN;
        SZ_WORD:   if (|req_addr[1:0])     chk = FLT_MISALIGN;
        SZ_DOUBLE: if (|req_addr[2:0])     chk = FLT_MISALIGN;
        default:   chk = FLT_NONE;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    mre_d      = mre_q;
    mwe_d      = mwe_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    be_d       = be_q;
    load_d     = load_q;
    size_d     = size_q;
    off_d      = off_q;
    sgn_d      = sgn_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    fault_d    = 1'b0;
    fcode_d    = FLT_NONE;
    case (state_q)
      IDLE: begin
        if (req_valid && (op == OP_LOAD || op == OP_STORE)) begin
          if (chk != FLT_NONE) begin
            fault_d = 1'b1;
            fcode_d = chk;
          end else begin
            state_d = ACCESS;
            mre_d   = (op == OP_LOAD);
            mwe_d   = (op == OP_STORE);
            addr_d  = req_addr & ~ABUS'(NB - 1);
            sdata_d = st_data;
            be_d    = st_be;
            load_d  = (op == OP_LOAD);
            size_d  = rsize;
            off_d   = req_addr[OW-1:0];
            sgn_d   = req_signed;
            rd_d    = req_rd;
            cnt_d   = CW'(1);
          end
        end
      end
      ACCESS: begin
        if (memReady) begin
          state_d = DONE;
          mre_d   = 1'b0;
          mwe_d   = 1'b0;
          if (load_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_data;
          end
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
          state_d = IDLE;
          mre_d   = 1'b0;
          mwe_d   = 1'b0;
          fault_d = 1'b1;
          fcode_d = FLT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mre_q      <= 1'b0;
      mwe_q      <= 1'b0;
      addr_q     <= '0;
      sdata_q    <= '0;
      be_q       <= '0;
      load_q     <= 1'b0;
      size_q     <= SZ_BYTE;
      off_q      <= '0;
      sgn_q      <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
      fcode_q    <= FLT_NONE;
    end else begin
      state_q    <= state_d;
      mre_q      <= mre_d;
      mwe_q      <= mwe_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      be_q       <= be_d;
      load_q     <= load_d;
      size_q     <= size_d;
      off_q      <= off_d;
      sgn_q      <= sgn_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
      fcode_q    <= fcode_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign MRE           = mre_q;
  assign MWE           = mwe_q;
  assign addressData   = addr_q;
  assign storeData     = sdata_q;
  assign byteEn        = be_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign busy_rd_valid = (state_q != IDLE) && load_q;
  assign busy_rd       = rd_q;
  assign fault         = fault_q;
  assign fault_code    = fcode_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit (DBUS=32, TIMEOUT=4)
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_signed;
  logic [1:0]  req_op, req_size;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_rd;
  logic        MRE, MWE;
  logic [31:0] addressData, storeData, loadedData, wb_data;
  logic [3:0]  byteEn;
  logic        memReady, wb_valid, busy_rd_valid, fault;
  logic [3:0]  wb_rd, busy_rd;
  logic [1:0]  fault_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DBUS(32), .ABUS(32), .RBUS(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .MRE(MRE), .MWE(MWE), .addressData(addressData), .storeData(storeData), .byteEn(byteEn),
    .loadedData(loadedData), .memReady(memReady),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_rd_valid(busy_rd_valid), .busy_rd(busy_rd),
    .fault(fault), .fault_code(fault_code)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge, then withdraws it.
  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] rd);
    req_valid = 1'b1; req_op = op; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0; loadedData = '0; memReady = 1'b0;
    tick(); tick();
    check("rst_ready", req_ready, 1);
    check("rst_mre", MRE, 0);
    check("rst_mwe", MWE, 0);
    check("rst_wbv", wb_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy_rd_valid, 0);
    check("rst_addr", addressData, 0);
    rst = 1'b1;
    tick();

    // 1: store word, memory ready at once
    memReady = 1'b1;
    issue(2'b10, 2'b10, 1'b0, 32'h08, 32'h0000003F, 4'd0);
    check("st_mwe", MWE, 1);
    check("st_mre", MRE, 0);
    check("st_addr", addressData, 32'h08);
    check("st_be", byteEn, 4'b1111);
    check("st_data", storeData, 32'h0000003F);
    check("st_busy", busy_rd_valid, 0);
    check("st_ready", req_ready, 0);
    tick();
    check("st_mwe_drop", MWE, 0);
    check("st_no_wb", wb_valid, 0);
    tick();
    check("st_idle", req_ready, 1);

    // 2: signed byte load from lane 1
    loadedData = 32'h00008000;
    issue(2'b01, 2'b00, 1'b1, 32'h05, 32'h0, 4'd5);
    check("lb_mre", MRE, 1);
    check("lb_addr", addressData, 32'h04);
    check("lb_be", byteEn, 4'b0010);
    check("lb_busy", busy_rd_valid, 1);
    check("lb_busy_rd", busy_rd, 5);
    tick();
    check("lb_wbv", wb_valid, 1);
    check("lb_wbrd", wb_rd, 5);
    check("lb_data_s", wb_data, 32'hFFFFFF80);
    check("lb_busy_done", busy_rd_valid, 1);
    tick();
    check("lb_wbv_once", wb_valid, 0);
    issue(2'b01, 2'b00, 1'b0, 32'h05, 32'h0, 4'd5);
    tick();
    check("lbu_data", wb_data, 32'h00000080);
    tick();

    // signed half from upper lanes
    loadedData = 32'h8001_0000;
    issue(2'b01, 2'b01, 1'b1, 32'h16, 32'h0, 4'd9);
    check("lh_be", byteEn, 4'b1100);
    tick();
    check("lh_data", wb_data, 32'hFFFF8001);
    tick();

    // 3: word load with three wait cycles; memReady wins over the timeout on the 4th
    memReady = 1'b0;
    loadedData = 32'hDEADBEEF;
    issue(2'b01, 2'b10, 1'b0, 32'h10, 32'h0, 4'd7);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("wait_mre_%0d", i), MRE, 1);
      check($sformatf("wait_ready_%0d", i), req_ready, 0);
      check($sformatf("wait_busy_%0d", i), busy_rd_valid, 1);
      if (i == 4) memReady = 1'b1;
      tick();
    end
    check("wait_mre_drop", MRE, 0);
    check("wait_wbv", wb_valid, 1);
    check("wait_data", wb_data, 32'hDEADBEEF);
    check("wait_no_fault", fault, 0);
    memReady = 1'b0;
    tick();

    // 4: misaligned half faults; a word request in the fault cycle is accepted
    issue(2'b01, 2'b01, 1'b0, 32'h03, 32'h0, 4'd1);
    check("mis_fault", fault, 1);
    check("mis_code", fault_code, 2'b01);
    check("mis_mre", MRE, 0);
    check("mis_busy", busy_rd_valid, 0);
    check("mis_ready", req_ready, 1);
    memReady = 1'b1;
    loadedData = 32'h12345678;
    issue(2'b01, 2'b10, 1'b0, 32'h20, 32'h0, 4'd2);
    check("mis_next_mre", MRE, 1);
    check("mis_fault_once", fault, 0);
    tick();
    check("mis_next_data", wb_data, 32'h12345678);
    check("mis_next_rd", wb_rd, 2);
    tick();
    // double on a 32-bit bus: illegal size outranks misalignment
    issue(2'b01, 2'b11, 1'b0, 32'h03, 32'h0, 4'd3);
    check("ill_code", fault_code, 2'b10);
    check("ill_mre", MRE, 0);
    // reserved op is not accepted
    issue(2'b11, 2'b10, 1'b0, 32'h00, 32'h0, 4'd3);
    check("rsvd_mre", MRE, 0);
    check("rsvd_fault", fault, 0);

    // 5: memory never answers
    memReady = 1'b0;
    issue(2'b01, 2'b10, 1'b0, 32'h30, 32'h0, 4'd4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_mre_%0d", i), MRE, 1);
      tick();
    end
    check("to_mre_drop", MRE, 0);
    check("to_fault", fault, 1);
    check("to_code", fault_code, 2'b11);
    check("to_no_wb", wb_valid, 0);
    check("to_busy", busy_rd_valid, 0);
    tick();
    check("to_fault_once", fault, 0);

    // 6: asynchronous reset during ACCESS
    issue(2'b01, 2'b10, 1'b0, 32'h40, 32'h0, 4'd6);
    check("ar_mre_before", MRE, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_mre_async", MRE, 0);
    check("ar_busy_async", busy_rd_valid, 0);
    tick();
    rst = 1'b1;
    memReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ar_no_wb_%0d", i), wb_valid, 0);
      tick();
    end
    issue(2'b10, 2'b00, 1'b0, 32'h43, 32'h000000A5, 4'd0);
    check("ar_st_mwe", MWE, 1);
    check("ar_st_data", storeData, 32'hA5A5A5A5);
    check("ar_st_be", byteEn, 4'b1000);
    check("ar_st_addr", addressData, 32'h40);
    tick();
    check("ar_st_drop", MWE, 0);
    tick();
    check("ar_idle", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
